// File: rtl/seq_player.sv
// Pattern sequencer: steps through a written pattern, one entry per divider tick, single-shot or looped.
// Start from a synchronised btn1 edge; outputs/busy/done are registered and only change on ticks.
module seq_player #(
  parameter int                OUT_W    = 2,
  parameter int                DEPTH    = 4,
  parameter int                DIV      = 16777216,
  parameter logic [OUT_W-1:0]  IDLE_VAL = '0,
  localparam int               AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn1,
  input  logic             stop,
  input  logic             loop,
  input  logic [AW:0]      seq_len,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [OUT_W-1:0] wr_data,
  output logic [OUT_W-1:0] outputs,
  output logic             busy,
  output logic             done
);

  localparam int          CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [1:0]       fill_q, fill_d;
  logic             arm_q, arm_d;
  logic             pend_q, pend_d;
  logic             stop_q, stop_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW:0]      len_q, len_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [OUT_W-1:0] mem_d [DEPTH];

  logic             tick;
  logic             rise;
  logic [AW:0]      eff_len;
  logic [AW-1:0]    idx_nxt;

  assign outputs = out_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_comb begin
    tick    = (cnt_q == CNT_MAX);
    cnt_d   = tick ? '0 : cnt_q + 1'b1;

    sync1_d = btn1;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    // Only arm once the chain shows a settled low, so a button held through reset is not an edge.
    arm_d   = arm_q | ((fill_q == 2'd2) & ~sync2_q);
    rise    = sync2_q & ~sync3_q & arm_q;

    if (seq_len == '0)          eff_len = (AW+1)'(1);
    else if (seq_len > DEPTH_L) eff_len = DEPTH_L;
    else                        eff_len = seq_len;

    idx_nxt = idx_q + 1'b1;

    state_d = state_q;
    pend_d  = pend_q;
    stop_d  = stop_q;
    idx_d   = idx_q;
    len_d   = len_q;
    out_d   = out_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (tick && pend_q) begin
          state_d = RUN;
          idx_d   = '0;
          len_d   = eff_len;
          out_d   = mem_q[0];
          pend_d  = 1'b0;
        end else begin
          if (tick) out_d = IDLE_VAL;
          if (rise) pend_d = 1'b1;
        end
      end
      RUN: begin
        stop_d = stop_q | stop;
        if (tick) begin
          if (stop_q) begin
            state_d = IDLE;
            out_d   = IDLE_VAL;
            stop_d  = 1'b0;
          end else if ({1'b0, idx_q} < len_q - 1'b1) begin
            idx_d = idx_nxt;
            out_d = mem_q[idx_nxt];
          end else if (loop) begin
            idx_d = '0;
            len_d = eff_len;
            out_d = mem_q[0];
          end else begin
            state_d = IDLE;
            out_d   = IDLE_VAL;
            done_d  = 1'b1;
            stop_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);

    // Reads above use mem_q, so a same-tick write is seen only on the next pass.
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      fill_q  <= 2'd0;
      arm_q   <= 1'b0;
      pend_q  <= 1'b0;
      stop_q  <= 1'b0;
      idx_q   <= '0;
      len_q   <= (AW+1)'(1);
      out_q   <= IDLE_VAL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      fill_q  <= fill_d;
      arm_q   <= arm_d;
      pend_q  <= pend_d;
      stop_q  <= stop_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: per-cycle behavioural model plus directed literal checks and a random phase.
module tb_seq_player;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn1 = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0;
  logic [2:0] seq_len = 3'd0;
  logic [1:0] wr_addr = 2'd0, wr_data = 2'd0;
  logic [1:0] outputs;
  logic       busy, done;

  int vec = 0;
  int bad = 0;

  seq_player #(.OUT_W(2), .DEPTH(DEPTH), .DIV(DIV), .IDLE_VAL(2'd0)) dut (
    .clk(clk), .rst(rst), .btn1(btn1), .stop(stop), .loop(loop), .seq_len(seq_len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .outputs(outputs), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: e counts clk edges since reset; a tick is every DIV-th edge.
  int         e = 0;
  bit         hist[$];
  bit         m_run = 0, m_pend = 0, m_stop = 0, m_done = 0;
  int         m_idx = 0, m_len = 1;
  logic [1:0] m_out = 2'd0;
  logic [1:0] m_pat [DEPTH];

  function automatic int efflen(input int s);
    if (s == 0) return 1;
    if (s > DEPTH) return DEPTH;
    return s;
  endfunction

  initial begin
    bit tick, rise, o_run, o_stop, o_pend;
    int o_idx;
    forever begin
      @(posedge clk);
      if (!rst) begin
        e = 0; hist = {}; hist.push_back(1'b0);
        m_run = 0; m_pend = 0; m_stop = 0; m_done = 0; m_idx = 0; m_len = 1; m_out = 2'd0;
        for (int i = 0; i < DEPTH; i++) m_pat[i] = 2'd0;
      end else begin
        o_run = m_run; o_stop = m_stop; o_pend = m_pend; o_idx = m_idx;
        e++;
        hist.push_back(btn1);
        tick = (e % DIV) == 0;
        // a real low-to-high of btn1 after reset is seen three edges after it is sampled
        rise = 1'b0;
        if (e >= 4) rise = hist[e-2] && !hist[e-3];
        m_done = 0;
        if (!o_run) begin
          m_stop = 0;
          if (tick && o_pend) begin
            m_run = 1; m_idx = 0; m_len = efflen(int'(seq_len)); m_out = m_pat[0]; m_pend = 0;
          end else begin
            if (tick) m_out = 2'd0;
            if (rise) m_pend = 1;
          end
        end else begin
          m_stop = o_stop | stop;
          if (tick) begin
            if (o_stop) begin
              m_run = 0; m_out = 2'd0; m_stop = 0;
            end else if (o_idx < m_len - 1) begin
              m_idx = o_idx + 1; m_out = m_pat[m_idx];
            end else if (loop) begin
              m_idx = 0; m_len = efflen(int'(seq_len)); m_out = m_pat[0];
            end else begin
              m_run = 0; m_out = 2'd0; m_done = 1; m_stop = 0;
            end
          end
        end
        if (wr_en) m_pat[wr_addr] = wr_data;
      end
      #1;
      chk("model_outputs", 32'(outputs), 32'(m_out));
      chk("model_busy", 32'(busy), 32'(m_run));
      chk("model_done", 32'(done), 32'(m_done));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] d);
    @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic pulse_btn();
    @(negedge clk); btn1 = 1'b1;
    cyc(2); btn1 = 1'b0;
  endtask

  task automatic wait_busy(input logic exp, input int lim, input string nm);
    int n = 0;
    while (busy !== exp && n < lim) begin
      @(negedge clk); n++;
    end
    if (busy !== exp) begin
      vec++; bad++;
      $display("FAIL %s: busy=%0b after %0d cycles, expected %0b", nm, busy, n, exp);
    end
  endtask

  initial begin
    cyc(2);
    chk("rst_outputs", 32'(outputs), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b1;

    wr(2'd0, 2'd2); wr(2'd1, 2'd1); wr(2'd2, 2'd3); wr(2'd3, 2'd0);

    // single shot, three steps
    seq_len = 3'd3; loop = 1'b0;
    pulse_btn(); wait_busy(1'b1, 40, "ss_start");
    chk("ss_step0", 32'(outputs), 32'd2);
    cyc(4); chk("ss_step1", 32'(outputs), 32'd1);
    cyc(4); chk("ss_step2", 32'(outputs), 32'd3);
    cyc(4); chk("ss_end_out", 32'(outputs), 32'd0);
    chk("ss_done", 32'(done), 32'd1);
    chk("ss_end_busy", 32'(busy), 32'd0);
    cyc(1); chk("ss_done_pulse", 32'(done), 32'd0);

    // loop with abort during the second pass step 1
    loop = 1'b1;
    pulse_btn(); wait_busy(1'b1, 40, "lp_start");
    chk("lp_s0", 32'(outputs), 32'd2);
    cyc(4); chk("lp_s1", 32'(outputs), 32'd1);
    cyc(4); chk("lp_s2", 32'(outputs), 32'd3);
    cyc(4); chk("lp_s3", 32'(outputs), 32'd2);
    cyc(4); chk("lp_s4", 32'(outputs), 32'd1);
    stop = 1'b1; cyc(1); stop = 1'b0; cyc(3);
    chk("lp_stop_out", 32'(outputs), 32'd0);
    chk("lp_stop_busy", 32'(busy), 32'd0);
    chk("lp_stop_nodone", 32'(done), 32'd0);

    // length clamping
    loop = 1'b0; seq_len = 3'd0;
    pulse_btn(); wait_busy(1'b1, 40, "len0_start");
    chk("len0_s0", 32'(outputs), 32'd2);
    cyc(4); chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    seq_len = 3'd7;
    pulse_btn(); wait_busy(1'b1, 40, "len7_start");
    chk("len7_s0", 32'(outputs), 32'd2);
    cyc(4); chk("len7_s1", 32'(outputs), 32'd1);
    cyc(4); chk("len7_s2", 32'(outputs), 32'd3);
    cyc(4); chk("len7_s3", 32'(outputs), 32'd0);
    chk("len7_s3_busy", 32'(busy), 32'd1);
    cyc(4); chk("len7_done", 32'(done), 32'd1);

    // presses during RUN are dropped, a later press restarts
    seq_len = 3'd3;
    pulse_btn(); wait_busy(1'b1, 40, "ign_start");
    pulse_btn(); wait_busy(1'b0, 40, "ign_end");
    cyc(24); chk("ign_no_restart", 32'(busy), 32'd0);
    pulse_btn(); wait_busy(1'b1, 40, "ign_restart");
    wait_busy(1'b0, 40, "ign_restart_end");

    // read-before-write on the tick that reads entry 1
    loop = 1'b1;
    pulse_btn(); wait_busy(1'b1, 40, "rbw_start");
    cyc(3); wr_en = 1'b1; wr_addr = 2'd1; wr_data = 2'd0;
    cyc(1); wr_en = 1'b0;
    chk("rbw_old", 32'(outputs), 32'd1);
    cyc(12); chk("rbw_new", 32'(outputs), 32'd0);
    stop = 1'b1; cyc(1); stop = 1'b0;
    wait_busy(1'b0, 20, "rbw_stop");

    // reset mid-run clears the pattern
    pulse_btn(); wait_busy(1'b1, 40, "mr_start");
    cyc(5); rst = 1'b0; cyc(1); rst = 1'b1;
    chk("mr_out", 32'(outputs), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    loop = 1'b0; seq_len = 3'd4; cyc(6);
    pulse_btn(); wait_busy(1'b1, 40, "mr_rerun");
    chk("mr_p0", 32'(outputs), 32'd0);
    for (int i = 1; i < 4; i++) begin
      cyc(4); chk("mr_pn", 32'(outputs), 32'd0);
      chk("mr_pn_busy", 32'(busy), 32'd1);
    end
    cyc(4); chk("mr_done", 32'(done), 32'd1);

    // button held through reset release is not a start
    btn1 = 1'b1; cyc(1); rst = 1'b0; cyc(1); rst = 1'b1;
    cyc(12); btn1 = 1'b0; cyc(20);
    chk("held_no_start", 32'(busy), 32'd0);

    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) btn1 = ~btn1;
      stop = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 99) == 0) loop = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) seq_len = 3'($urandom_range(0, 7));
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 2'($urandom_range(0, 3));
      rst     = ($urandom_range(0, 699) != 0);
    end
    rst = 1'b1; wr_en = 1'b0;
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 Parameter OUT_W, default 2, width of outputs and of each pattern entry.
REQ-002 Parameter DEPTH, default 4, number of pattern entries (>=2); AW = clog2(DEPTH).
REQ-003 Parameter DIV, default 16777216, clk cycles per step tick (>=1; DIV=1 ticks every cycle).
REQ-004 Parameter IDLE_VAL, default 0, OUT_W-bit value driven on outputs in IDLE.
REQ-005 clk  in  1  single clock; every register updates on its rising edge only, no derived clocks.
REQ-006 rst  in  1  synchronous reset, active-low; sampled on rising clk.
REQ-007 btn1  in  1  asynchronous start button, level.
REQ-008 stop  in  1  synchronous abort request, level.
REQ-009 loop  in  1  mode: 0 single-shot, 1 repeat pattern until stop.
REQ-010 seq_len  in  AW+1  number of active entries.
REQ-011 wr_en  in  1  pattern write strobe.
REQ-012 wr_addr  in  AW  pattern write address.
REQ-013 wr_data  in  OUT_W  pattern write data.
REQ-014 outputs  out  OUT_W  registered current step value.
REQ-015 busy  out  1  high while state is RUN.
REQ-016 done  out  1  one-cycle pulse on normal completion.

Function
REQ-017 Divider: counter 0..DIV-1, tick = 1-cycle pulse when counter = DIV-1, counter then wraps to 0; runs freely in all states.
REQ-018 btn1 passes a 2-flop synchroniser then rising-edge detect; an edge seen in IDLE sets start_pend; edges seen in RUN are discarded.
REQ-019 Effective length L = 1 if seq_len = 0, DEPTH if seq_len > DEPTH, else seq_len; sampled only at the start tick and at each wrap.
REQ-020 States IDLE and RUN only; step index idx is AW bits.
REQ-021 IDLE, tick with start_pend: -> RUN, idx=0, outputs=pattern[0], start_pend cleared; tick without start_pend: remain, outputs=IDLE_VAL.
REQ-022 RUN, tick, stop latched: -> IDLE, outputs=IDLE_VAL, no done pulse, stop latch cleared.
REQ-023 RUN, tick, idx < L-1: idx+1, outputs=pattern[idx+1].
REQ-024 RUN, tick, idx = L-1, loop=1: idx=0, outputs=pattern[0].
REQ-025 RUN, tick, idx = L-1, loop=0: -> IDLE, outputs=IDLE_VAL, done=1 for exactly one clk.
REQ-026 stop high on any clk cycle while RUN sets the stop latch; stop in IDLE is ignored and clears any stale latch.
REQ-027 No state or output change between ticks; outputs, busy, done are registered.
REQ-028 wr_en writes pattern[wr_addr] in any state; a write to the entry read on the same tick returns the old value (read-before-write).
REQ-029 L=1, loop=0: exactly one step of pattern[0], then IDLE with done.
REQ-030 Latency btn1 rise -> RUN: 3 clk to start_pend, then up to DIV clk to next tick.

Reset
REQ-031 rst low at a clk edge, in any state or mid-sequence: state=IDLE, outputs=IDLE_VAL, busy=0, done=0, idx=0, divider=0, start_pend=0, stop latch=0, synchroniser flops=0, all pattern entries=0.
REQ-032 First tick after rst release occurs DIV clk later; a btn1 held high through reset release produces no start edge.

Verification (OUT_W=2, DEPTH=4, DIV=4, IDLE_VAL=0)
REQ-033 Load {2,1,3,0}, seq_len=3, loop=0, pulse btn1 -> outputs 2,1,3 each for 4 clk, then 0 with done=1 one clk, busy low.
REQ-034 Same pattern, loop=1 -> 2,1,3,2,1,3...; assert stop during second step 1 -> at next tick outputs=0, busy=0, done never pulsed.
REQ-035 seq_len=0 and seq_len=7 -> one step of 2 then IDLE; four steps 2,1,3,0 then IDLE respectively.
REQ-036 btn1 pulses during RUN -> no restart after completion; btn1 pulse after done -> new sequence.
REQ-037 Write pattern[1]=0 on the tick that reads entry 1 -> step shows old value 1; next loop pass shows 0.
REQ-038 rst low mid-RUN for one clk -> next cycle outputs=0, busy=0, all pattern entries read back 0 on a subsequent run.
